uart_cmd_responder: RTL and testbench

Device-side command engine for the UART register-access protocol. It parses host command frames arriving as bytes from the UART receiver, performs single or burst 16-bit register writes and reads on the local register bus, and returns read data or a write acknowledge as bytes to the UART transmitter. It sits between the device UART byte interface and the register block.

---
 rtl/uart_cmd_responder.sv | 166 ++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: device-side command engine for the UART register-access
// protocol. Parses CMD/ADDR_H/ADDR_L[/data] frames from the UART receiver,
// issues single or burst 16-bit register writes/reads on the local bus, and
// returns read data (MSB first) or a write acknowledge byte to the transmitter.
//
// Optional feature macro: UART_CMD_TIMEOUT_EN
//   defined   : a partial frame is abandoned after TIMEOUT_CYCLES idle clocks
//               between received bytes; frame_err pulses for one cycle.
//   undefined : the parser waits indefinitely and frame_err is tied low.
module uart_cmd_responder #(
`ifdef UART_CMD_TIMEOUT_EN
  parameter int          TIMEOUT_CYCLES = 100000,
`endif
  parameter logic [7:0]  WR_ACK         = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] bus_addr,
  output logic        bus_wr,
  output logic [15:0] bus_wdata,
  output logic        bus_rd,
  input  logic [15:0] bus_rdata,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [3:0] {
    IDLE, ADDR_H, ADDR_L, WDATA_H, WDATA_L, WRITE,
    RD_ISSUE, RD_WAIT, TX_H, TX_L, TX_ACK
  } state_t;

  state_t     state;
  logic       is_wr;     // latched CMD[7]
  logic [3:0] word_cnt;  // words remaining after the current one
  logic [7:0] rd_lo;     // low byte of the read word; high byte goes straight to tx_data

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt;
`else
  assign frame_err = 1'b0;
`endif

  // The frame always ends in IDLE, so busy is a direct decode of the state register.
  assign busy = (state != IDLE);

  // Frame parser, bus sequencer and transmit handshake in one registered FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      word_cnt  <= 4'd0;
      rd_lo     <= 8'h00;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_wr    <= 1'b0;
      bus_wdata <= 16'h0000;
      bus_rd    <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      to_cnt    <= '0;
      frame_err <= 1'b0;
`endif
    end else begin
      // NOTE: strobes default low every cycle and are raised only by the state
      // that owns them, which makes them exactly one cycle wide; all state uses
      // non-blocking assignments so every register updates from pre-edge values.
      bus_wr <= 1'b0;
      bus_rd <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      frame_err <= 1'b0;
`endif
      unique case (state)
        IDLE: if (rx_valid) begin
          is_wr    <= rx_data[7];
          word_cnt <= rx_data[3:0];
          state    <= ADDR_H;
        end
        ADDR_H: if (rx_valid) begin
          bus_addr[15:8] <= rx_data;
          state          <= ADDR_L;
        end
        ADDR_L: if (rx_valid) begin
          bus_addr[7:0] <= rx_data;
          if (is_wr) begin
            state <= WDATA_H;
          end else begin
            // Raise bus_rd on entry so it is high during RD_ISSUE itself.
            bus_rd <= 1'b1;
            state  <= RD_ISSUE;
          end
        end
        WDATA_H: if (rx_valid) begin
          bus_wdata[15:8] <= rx_data;
          state           <= WDATA_L;
        end
        WDATA_L: if (rx_valid) begin
          bus_wdata[7:0] <= rx_data;
          bus_wr         <= 1'b1;
          state          <= WRITE;
        end
        WRITE: begin
          bus_addr <= {bus_addr[15:12], bus_addr[11:0] + 12'd1};
          if (word_cnt == 4'd0) begin
            tx_data  <= WR_ACK;
            tx_valid <= 1'b1;
            state    <= TX_ACK;
          end else begin
            word_cnt <= word_cnt - 4'd1;
            state    <= WDATA_H;
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          // bus_rdata is valid this cycle, one after the bus_rd strobe.
          rd_lo    <= bus_rdata[7:0];
          tx_data  <= bus_rdata[15:8];
          tx_valid <= 1'b1;
          state    <= TX_H;
        end
        TX_H: if (tx_ready) begin
          tx_data <= rd_lo;
          state   <= TX_L;
        end
        TX_L: if (tx_ready) begin
          tx_valid <= 1'b0;
          bus_addr <= {bus_addr[15:12], bus_addr[11:0] + 12'd1};
          if (word_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            word_cnt <= word_cnt - 4'd1;
            bus_rd   <= 1'b1;
            state    <= RD_ISSUE;
          end
        end
        TX_ACK: if (tx_ready) begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef UART_CMD_TIMEOUT_EN
      // Inter-byte idle timer; only the receive-side states can stall on the host.
      if (state inside {ADDR_H, ADDR_L, WDATA_H, WDATA_L}) begin
        if (rx_valid) begin
          to_cnt <= '0;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          to_cnt    <= '0;
          frame_err <= 1'b1;
          state     <= IDLE;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Testbench for uart_cmd_responder: drives host frames byte by byte, emulates
// the register block, and checks bus traffic and response bytes against a
// transaction-level model of the protocol.
module tb_uart_cmd_responder;

  typedef logic [15:0] words_t [16];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] bus_addr;
  logic        bus_wr;
  logic [15:0] bus_wdata;
  logic        bus_rd;
  logic [15:0] bus_rdata = 16'h0000;
  logic        busy;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  always #5 clk = ~clk;

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_responder #(.TIMEOUT_CYCLES(100), .WR_ACK(8'hA5)) dut (
`else
  uart_cmd_responder #(.WR_ACK(8'hA5)) dut (
`endif
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_rd(bus_rd), .bus_rdata(bus_rdata), .busy(busy), .frame_err(frame_err)
  );

  // Preloaded content of any register not yet written.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Register block emulation: write on strobe, read data one cycle after bus_rd.
  logic [15:0] regs [int];
  always @(posedge clk) begin
    if (bus_wr) regs[int'(bus_addr)] = bus_wdata;
    if (bus_rd) bus_rdata <= regs.exists(int'(bus_addr)) ? regs[int'(bus_addr)] : init_val(bus_addr);
  end

  // Observed traffic logs and transmit-stability watcher.
  logic [31:0] wr_q [$];
  logic [15:0] rd_q [$];
  logic [7:0]  tx_q [$];
  int          ferr_cnt = 0;
  int          stab_viol = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  data_prev = 8'h00;
  always @(posedge clk) begin
    if (bus_wr) wr_q.push_back({bus_addr, bus_wdata});
    if (bus_rd) rd_q.push_back(bus_addr);
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (stall_prev && rst_n && (tx_valid !== 1'b1 || tx_data !== data_prev)) stab_viol <= stab_viol + 1;
    stall_prev <= rst_n && tx_valid && !tx_ready;
    data_prev  <= tx_data;
  end

  // Transmitter ready driver.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       tx_ready = 1'($urandom_range(0, 1));
        2:       tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Reference model: the register contents as the protocol says they should be.
  logic [15:0] model_mem [int];
  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_val(a);
  endfunction

  // Address of word i of a burst: offset wraps modulo 4096, block id fixed.
  function automatic logic [15:0] word_addr(input logic [15:0] base, input int i);
    int off;
    off = (int'(base[11:0]) + i) % 4096;
    return {base[15:12], 12'(off)};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Send one frame, check strobe timing on the fly, then compare all traffic.
  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr,
                           input words_t w, input string tag);
    int ws, rs, ts, n;
    bit ok;
    logic [15:0] a;
    logic [31:0] exp_wr [$];
    logic [15:0] exp_rd [$];
    logic [7:0]  exp_tx [$];
    n  = int'(cmd[3:0]) + 1;
    ws = wr_q.size();
    rs = rd_q.size();
    ts = tx_q.size();
    send_byte(cmd);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    if (cmd[7]) begin
      for (int i = 0; i < n; i++) begin
        a = word_addr(addr, i);
        send_byte(w[i][15:8]);
        send_byte(w[i][7:0]);
        checks++;
        if (bus_wr !== 1'b1 || bus_addr !== a || bus_wdata !== w[i]) begin
          errors++;
          $display("FAIL %s wr_strobe[%0d]: got wr=%b addr=%h data=%h, expected wr=1 addr=%h data=%h",
                   tag, i, bus_wr, bus_addr, bus_wdata, a, w[i]);
        end
        model_mem[int'(a)] = w[i];
        exp_wr.push_back({a, w[i]});
      end
      exp_tx.push_back(8'hA5);
    end else begin
      for (int i = 0; i < n; i++) begin
        a = word_addr(addr, i);
        exp_rd.push_back(a);
        exp_tx.push_back(model_rd(a)[15:8]);
        exp_tx.push_back(model_rd(a)[7:0]);
      end
      checks++;
      if (bus_rd !== 1'b1 || bus_addr !== addr) begin
        errors++;
        $display("FAIL %s rd_strobe: got rd=%b addr=%h, expected rd=1 addr=%h", tag, bus_rd, bus_addr, addr);
      end
      @(posedge clk); #1;
      checks++;
      if (tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s tx_early: got tx_valid=%b at t+1, expected 0", tag, tx_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_tx[0]) begin
        errors++;
        $display("FAIL %s tx_first: got valid=%b data=%h at t+2, expected valid=1 data=%h",
                 tag, tx_valid, tx_data, exp_tx[0]);
      end
    end
    wait_idle(4000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s idle_timeout: busy still %b, expected 0", tag, busy);
    end
    checks++;
    if (wr_q.size() - ws !== exp_wr.size() || rd_q.size() - rs !== exp_rd.size() ||
        tx_q.size() - ts !== exp_tx.size()) begin
      errors++;
      $display("FAIL %s counts: got wr=%0d rd=%0d tx=%0d, expected wr=%0d rd=%0d tx=%0d", tag,
               wr_q.size() - ws, rd_q.size() - rs, tx_q.size() - ts, exp_wr.size(), exp_rd.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_wr.size() && ws + i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[ws + i] !== exp_wr[i]) begin
        errors++;
        $display("FAIL %s write[%0d]: got %h, expected %h", tag, i, wr_q[ws + i], exp_wr[i]);
      end
    end
    for (int i = 0; i < exp_rd.size() && rs + i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[rs + i] !== exp_rd[i]) begin
        errors++;
        $display("FAIL %s read_addr[%0d]: got %h, expected %h", tag, i, rd_q[rs + i], exp_rd[i]);
      end
    end
    for (int i = 0; i < exp_tx.size() && ts + i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[ts + i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL %s tx_byte[%0d]: got %h, expected %h", tag, i, tx_q[ts + i], exp_tx[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx_data !== 8'h00 || tx_valid !== 1'b0 || bus_addr !== 16'h0000 || bus_wr !== 1'b0 ||
        bus_wdata !== 16'h0000 || bus_rd !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: got tx=%h/%b addr=%h wr=%b wd=%h rd=%b busy=%b ferr=%b, expected all zero",
               tx_data, tx_valid, bus_addr, bus_wr, bus_wdata, bus_rd, busy, frame_err);
    end
  endtask

  task automatic test_single();
    words_t w;
    int ts;
    w    = '{default: 16'h0000};
    w[0] = 16'h8888;
    run_frame(8'h80, 16'h2008, w, "single_write");
    ts = tx_q.size();
    run_frame(8'h00, 16'h2008, w, "single_read");
    checks++;
    if (tx_q.size() < ts + 2 || tx_q[ts] !== 8'h88 || tx_q[ts + 1] !== 8'h88) begin
      errors++;
      $display("FAIL single_read_value: got %0d new bytes, expected 88 88", tx_q.size() - ts);
    end
  endtask

  task automatic test_burst();
    words_t w;
    for (int i = 0; i < 15; i++) w[i] = 16'(16'h1111 * (i + 1));
    w[15] = 16'hABCD;
    run_frame(8'h8F, 16'h2001, w, "burst_write");
    run_frame(8'h0F, 16'h2001, w, "burst_read");
  endtask

  task automatic test_wrap();
    words_t w;
    int rs;
    w  = '{default: 16'h0000};
    rs = rd_q.size();
    run_frame(8'h01, 16'h2FFF, w, "wrap_read");
    checks++;
    if (rd_q.size() < rs + 2 || rd_q[rs] !== 16'h2FFF || rd_q[rs + 1] !== 16'h2000) begin
      errors++;
      $display("FAIL wrap_addr: got %0d reads, expected 2FFF then 2000", rd_q.size() - rs);
    end
  endtask

  task automatic test_backpressure();
    words_t w;
    int v0;
    w  = '{default: 16'h0000};
    v0 = stab_viol;
    rdy_mode = 2;
    fork
      run_frame(8'h02, 16'h3100, w, "backpressure");
      begin
        logic [7:0] d0;
        int k;
        for (k = 0; k < 500 && tx_valid !== 1'b1; k++) @(posedge clk);
        #1;
        d0 = tx_data;
        repeat (50) @(posedge clk);
        #2;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== d0) begin
          errors++;
          $display("FAIL backpressure_hold: got valid=%b data=%h, expected valid=1 data=%h", tx_valid, tx_data, d0);
        end
        rdy_mode = 0;
      end
    join
    checks++;
    if (stab_viol !== v0) begin
      errors++;
      $display("FAIL tx_stability: got %0d violations, expected 0", stab_viol - v0);
    end
  endtask

  task automatic test_timeout();
    words_t w;
    int ws, f0;
    bit ok;
    w  = '{default: 16'h0000};
    ws = wr_q.size();
    f0 = ferr_cnt;
    send_byte(8'h80);
    send_byte(8'h20);
    repeat (150) @(posedge clk);
    #1;
`ifdef UART_CMD_TIMEOUT_EN
    checks++;
    if (ferr_cnt - f0 !== 1 || busy !== 1'b0 || wr_q.size() !== ws) begin
      errors++;
      $display("FAIL timeout_abort: got ferr_pulses=%0d busy=%b writes=%0d, expected 1 0 0",
               ferr_cnt - f0, busy, wr_q.size() - ws);
    end
    w[0] = 16'h1357;
    run_frame(8'h80, 16'h2040, w, "after_timeout");
`else
    checks++;
    if (ferr_cnt !== f0 || busy !== 1'b1 || wr_q.size() !== ws) begin
      errors++;
      $display("FAIL stall_wait: got ferr_pulses=%0d busy=%b writes=%0d, expected 0 1 0",
               ferr_cnt - f0, busy, wr_q.size() - ws);
    end
    send_byte(8'h08);
    send_byte(8'h12);
    send_byte(8'h34);
    model_mem[16'h2008] = 16'h1234;
    wait_idle(100, ok);
    checks++;
    if (!ok || wr_q.size() !== ws + 1 || wr_q[ws] !== {16'h2008, 16'h1234} || tx_q[tx_q.size() - 1] !== 8'hA5) begin
      errors++;
      $display("FAIL stall_resume: got idle=%b writes=%0d, expected idle, one write 2008=1234 and A5",
               ok, wr_q.size() - ws);
    end
`endif
  endtask

  task automatic test_mid_reset();
    words_t w;
    int ws, rs, ts;
    w  = '{default: 16'h0000};
    ws = wr_q.size();
    rs = rd_q.size();
    ts = tx_q.size();
    send_byte(8'h81);
    send_byte(8'h20);
    send_byte(8'h50);
    send_byte(8'hDE);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus_wr !== 1'b0 || bus_rd !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: got busy=%b wr=%b rd=%b txv=%b, expected all 0", busy, bus_wr, bus_rd, tx_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (wr_q.size() !== ws || rd_q.size() !== rs || tx_q.size() !== ts || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got writes=%0d reads=%0d tx=%0d busy=%b, expected none and idle",
               wr_q.size() - ws, rd_q.size() - rs, tx_q.size() - ts, busy);
    end
    w[0] = 16'hBEEF;
    run_frame(8'h80, 16'h2050, w, "after_reset");
  endtask

  task automatic test_random();
    words_t w;
    logic [7:0]  cmd;
    logic [15:0] addr;
    int v0;
    v0 = stab_viol;
    rdy_mode = 1;
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < 16; i++) w[i] = 16'($urandom);
      cmd  = 8'($urandom);
      addr = 16'($urandom);
      if (f % 3 == 0) addr[11:0] = 12'(12'hFF0 + $urandom_range(0, 15));
      if (f % 4 == 0) addr[15:12] = 4'h2;
      run_frame(cmd, addr, w, $sformatf("random%0d", f));
    end
    rdy_mode = 0;
    checks++;
    if (stab_viol !== v0) begin
      errors++;
      $display("FAIL random_tx_stability: got %0d violations, expected 0", stab_viol - v0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_backpressure();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
